// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ULA and ULA_LD_SD results in per-source FIFOs and broadcasts one word per cycle on the CDB with round-robin priority.
// Ports: clock/reset (async, active-high); ula_result, ld_sd_result (16-bit words, INVALID = idle);
// cdb (registered broadcast word), cdb_from_ula (word came from ULA FIFO), stall_ula/stall_ld_sd (FIFO full),
// overflow (sticky, a valid word was dropped).
module cdb_arbiter #(
    parameter int          DEPTH   = 2,
    parameter logic [15:0] INVALID = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ula_result,
    input  logic [15:0] ld_sd_result,
    output logic [15:0] cdb,
    output logic        cdb_from_ula,
    output logic        stall_ula,
    output logic        stall_ld_sd,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    // Index 0 is the ULA source, index 1 is the LD_SD source.
    logic [15:0]   mem    [2][DEPTH];
    logic [AW-1:0] rd_ptr [2];
    logic [AW-1:0] wr_ptr [2];
    logic [CW-1:0] cnt    [2];
    logic [15:0]   din    [2];
    logic [1:0]    pop, push, drop;
    logic          last_ld;
    always_comb begin
        din[0] = ula_result;
        din[1] = ld_sd_result;
        // ULA wins when it is the only non-empty source or when LD_SD had the last grant.
        pop[0] = (cnt[0] != '0) && ((cnt[1] == '0) || last_ld);
        pop[1] = (cnt[1] != '0) && !pop[0];
        for (int i = 0; i < 2; i++) begin
            // A full FIFO still accepts a push when it is popped on the same edge.
            push[i] = (din[i] != INVALID) && ((cnt[i] != FULL) || pop[i]);
            drop[i] = (din[i] != INVALID) && !push[i];
        end
    end
    assign stall_ula   = cnt[0] == FULL;
    assign stall_ld_sd = cnt[1] == FULL;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb          <= INVALID;
            cdb_from_ula <= 1'b0;
            overflow     <= 1'b0;
            last_ld      <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            cdb          <= pop[0] ? mem[0][rd_ptr[0]] : pop[1] ? mem[1][rd_ptr[1]] : INVALID;
            cdb_from_ula <= pop[0];
            last_ld      <= pop[1] ? 1'b1 : pop[0] ? 1'b0 : last_ld;
            overflow     <= overflow | (|drop);
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= rd_ptr[i] + AW'(pop[i]);
                wr_ptr[i] <= wr_ptr[i] + AW'(push[i]);
                cnt[i]    <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end
    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= din[i];
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with a queue-based reference model and literal checks.
module tb_cdb_arbiter;
    localparam int DEPTH = 2;
    localparam logic [15:0] INV = 16'hFFFF;
    logic        clock = 0;
    logic        reset = 1;
    logic [15:0] ula_result = INV;
    logic [15:0] ld_sd_result = INV;
    logic [15:0] cdb;
    logic        cdb_from_ula, stall_ula, stall_ld_sd, overflow;
    int total = 0;
    int bad = 0;
    bit chk_en = 0;
    cdb_arbiter #(.DEPTH(DEPTH), .INVALID(INV)) dut (
        .clock(clock), .reset(reset), .ula_result(ula_result), .ld_sd_result(ld_sd_result),
        .cdb(cdb), .cdb_from_ula(cdb_from_ula), .stall_ula(stall_ula),
        .stall_ld_sd(stall_ld_sd), .overflow(overflow)
    );
    always #5 clock = ~clock;
    // Reference model: one queue per source, round-robin chosen from queue occupancy.
    logic [15:0] mq_u[$];
    logic [15:0] mq_l[$];
    logic [15:0] m_cdb;
    bit m_from, m_ovf, m_last_ula;
    int su, sl;
    bit gu, gl;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq_u.delete();
            mq_l.delete();
            m_cdb = INV;
            m_from = 0;
            m_ovf = 0;
            m_last_ula = 0;
        end else begin
            su = mq_u.size();
            sl = mq_l.size();
            gu = (su > 0) && (sl == 0 || !m_last_ula);
            gl = (sl > 0) && !gu;
            if (gu) begin
                m_cdb = mq_u.pop_front(); m_from = 1; m_last_ula = 1;
            end else if (gl) begin
                m_cdb = mq_l.pop_front(); m_from = 0; m_last_ula = 0;
            end else begin
                m_cdb = INV; m_from = 0;
            end
            if (ula_result != INV) begin
                if (su < DEPTH || gu) mq_u.push_back(ula_result); else m_ovf = 1;
            end
            if (ld_sd_result != INV) begin
                if (sl < DEPTH || gl) mq_l.push_back(ld_sd_result); else m_ovf = 1;
            end
        end
    end
    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, got, exp, $time);
        end
    endtask
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model.cdb", cdb, m_cdb);
            chk("model.from_ula", 16'(cdb_from_ula), 16'(m_from));
            chk("model.stall_ula", 16'(stall_ula), 16'(mq_u.size() == DEPTH));
            chk("model.stall_ld_sd", 16'(stall_ld_sd), 16'(mq_l.size() == DEPTH));
            chk("model.overflow", 16'(overflow), 16'(m_ovf));
        end
    end
    task automatic step(input logic [15:0] u, input logic [15:0] l);
        ula_result = u;
        ld_sd_result = l;
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset();
        ula_result = INV;
        ld_sd_result = INV;
        reset = 1;
        #2;
        reset = 0;
    endtask
    initial begin
        @(posedge clock);
        #1;
        reset = 0;
        chk("rst.cdb", cdb, INV);
        chk("rst.from", 16'(cdb_from_ula), 16'd0);
        chk("rst.stall", 16'({stall_ula, stall_ld_sd}), 16'd0);
        chk("rst.ovf", 16'(overflow), 16'd0);
        chk_en = 1;
        // Mid-operation reset with one word in each FIFO.
        step(16'h8001, 16'h2001);
        step(16'h8002, INV);
        chk("pre_rst.cdb", cdb, 16'h8001);
        reset = 1;
        #1;
        chk("async_rst.cdb", cdb, INV);
        chk("async_rst.stall", 16'({stall_ula, stall_ld_sd}), 16'd0);
        #1;
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step(INV, INV);
            chk("post_rst.cdb", cdb, INV);
        end
        // Single ULA word.
        do_reset();
        step(16'h8405, INV);
        step(INV, INV);
        chk("single.cdb", cdb, 16'h8405);
        chk("single.from", 16'(cdb_from_ula), 16'd1);
        step(INV, INV);
        chk("single.idle", cdb, INV);
        // First tie goes to ULA.
        do_reset();
        step(16'h4412, 16'h2003);
        step(INV, INV);
        chk("tie.first", cdb, 16'h4412);
        chk("tie.first_from", 16'(cdb_from_ula), 16'd1);
        step(INV, INV);
        chk("tie.second", cdb, 16'h2003);
        chk("tie.second_from", 16'(cdb_from_ula), 16'd0);
        step(INV, INV);
        chk("tie.idle", cdb, INV);
        // Both sources every cycle for 6 edges.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(16'h8000 + 16'(k), 16'h2000 + 16'(k));
            if (k == 1) begin
                chk("sat.e2.cdb", cdb, 16'h8000);
                chk("sat.e2.stall_ld", 16'(stall_ld_sd), 16'd1);
                chk("sat.e2.stall_ula", 16'(stall_ula), 16'd0);
            end
            if (k == 2) begin
                chk("sat.e3.cdb", cdb, 16'h2000);
                chk("sat.e3.stall_ula", 16'(stall_ula), 16'd1);
                chk("sat.e3.ovf", 16'(overflow), 16'd0);
            end
            if (k == 3) begin
                chk("sat.e4.cdb", cdb, 16'h8001);
                chk("sat.e4.ovf", 16'(overflow), 16'd1);
            end
        end
        for (int k = 0; k < 6; k++) step(INV, INV);
        chk("sat.drained", cdb, INV);
        chk("sat.ovf_sticky", 16'(overflow), 16'd1);
        // Full LD_SD FIFO accepts a push on the edge it is popped.
        do_reset();
        step(16'h8001, 16'h2101);
        step(INV, 16'h2102);
        chk("fullpop.stall_pre", 16'(stall_ld_sd), 16'd1);
        step(INV, 16'h2107);
        chk("fullpop.cdb", cdb, 16'h2101);
        chk("fullpop.stall", 16'(stall_ld_sd), 16'd1);
        chk("fullpop.ovf", 16'(overflow), 16'd0);
        step(INV, INV);
        chk("fullpop.next", cdb, 16'h2102);
        step(INV, INV);
        chk("fullpop.late", cdb, 16'h2107);
        chk("fullpop.ovf_end", 16'(overflow), 16'd0);
        // Ten ULA-only words stream through with one cycle of latency.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(16'h8100 + 16'(k), INV);
            if (k > 0) chk("stream.cdb", cdb, 16'h8100 + 16'(k - 1));
            chk("stream.stall", 16'(stall_ula), 16'd0);
        end
        step(INV, INV);
        chk("stream.last", cdb, 16'h8109);
        step(INV, INV);
        chk("stream.idle", cdb, INV);
        @(negedge clock);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits between the two functional units and the common data bus (CDB): ULA (R-type ops) and ULA_LD_SD (load/store address calc).
- Each unit emits one 16-bit CDB word per cycle, or 16'hFFFF when idle. Both can complete in the same cycle.
- The block buffers each unit's results in a small per-source FIFO and drives exactly one word per cycle onto the CDB, using round-robin priority.
- It raises per-source stall signals so the reservation station holds dispatch while that source's FIFO is full.

Parameters:
- DEPTH, 2, entries per source FIFO (power of two, ≥2).
- INVALID, 16'hFFFF, idle/invalid CDB word.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- ula_result  in  16  ULA output word; valid when != INVALID.
- ld_sd_result  in  16  ULA_LD_SD output word; valid when != INVALID.
- cdb  out  16  registered CDB word; INVALID when no broadcast.
- cdb_from_ula  out  1  1 = current cdb word came from the ULA FIFO; 0 = from the LD_SD FIFO or idle.
- stall_ula  out  1  ULA FIFO count == DEPTH.
- stall_ld_sd  out  1  LD_SD FIFO count == DEPTH.
- overflow  out  1  sticky; set when a valid word is dropped.

Behaviour:
- Reset (async, immediate):
  - cdb = INVALID, cdb_from_ula = 0, overflow = 0.
  - Both FIFOs empty: pointers and counts = 0.
  - stall_* = 0.
  - last_grant = LD_SD, so the first tie goes to ULA.
  - Reset asserted mid-operation discards all buffered words. Nothing is broadcast afterwards.
- Words pass through unmodified. Bits [15:13] (one-hot dest), [12:11] (RS position), [10] (unit tag) and [9:0] (data) are not altered.
- Per posedge, evaluated on pre-edge FIFO state:
  - Arbitration:
    - If both FIFOs are non-empty, grant the source ≠ last_grant.
    - If only one FIFO is non-empty, grant it.
    - If neither is non-empty, no grant.
  - On a grant:
    - cdb ← head of the granted FIFO; pop it.
    - cdb_from_ula ← (grant == ULA).
    - last_grant ← granted source.
  - With no grant: cdb ← INVALID, cdb_from_ula ← 0, last_grant unchanged.
  - Push: a valid input is written to the tail of its FIFO if pre-edge count < DEPTH, or if the same FIFO is popped in this edge (full + pop + push is accepted).
  - Otherwise the word is dropped and overflow ← 1, held until reset.
  - count updates by push − pop. Pointers wrap modulo DEPTH.
- Latency: a word sampled at edge N appears on cdb at the earliest at edge N+1. There is no combinational bypass.
- stall_* are combinational from the registered counts: count == DEPTH.
- Ordering: FIFO order per source. No ordering guarantee across sources beyond round-robin.
- Throughput: one CDB word per cycle. Sustained input from both sources fills the FIFOs and asserts the stalls.
- Both inputs INVALID with both FIFOs empty: cdb stays INVALID indefinitely.

Test Plan:
- Reset while both FIFOs hold 1 word, asserted between edges → cdb = FFFF and stall_* = 0 immediately; cdb remains FFFF on following edges with inputs idle.
- Single ULA word 16'h8405 at edge 1, then idle → cdb = 8405 with cdb_from_ula = 1 after edge 2; cdb = FFFF after edge 3.
- Simultaneous ULA 16'h4412 and LD_SD 16'h2003 at edge 1 after reset → edge 2 cdb = 4412 (ULA wins first tie); edge 3 cdb = 2003 with cdb_from_ula = 0; edge 4 cdb = FFFF.
- Both sources send a new valid word every cycle for 6 edges:
  - cdb alternates ULA/LD_SD each cycle.
  - stall_ula and stall_ld_sd assert once count = 2.
  - overflow sets on the first push rejected into a full un-popped FIFO.
  - Accepted words drain in FIFO order.
- LD_SD FIFO full (2 words), ULA empty, LD_SD pushes 16'h2107 in the same edge it is popped → push accepted, overflow stays 0, stall_ld_sd stays 1; 2107 is broadcast two cycles later.
- Ten consecutive ULA-only words with the LD_SD input idle → one word per cycle, no stall; output matches input delayed by 1 cycle.
